// File: rtl/softmax_unit_if.sv
// rtl/softmax_unit_if.sv - start/score-row and probability-row bundle for softmax_unit
interface softmax_unit_if #(
    parameter int ARRAYWIDTH = 4,
    parameter int IN_W       = 32,
    parameter int OUT_W      = 32
);
    logic                        softmax_en;
    logic [ARRAYWIDTH*IN_W-1:0]  Xi;
    logic [ARRAYWIDTH*OUT_W-1:0] out;
    logic                        out_valid;

    modport master (output softmax_en, Xi, input out, out_valid);
    modport slave  (input softmax_en, Xi, output out, out_valid);
endinterface

// File: rtl/softmax_unit.sv
// rtl/softmax_unit.sv - integer softmax over one row, Q22.10 output, 16-cycle schedule
// Quotients need only 11 bits, so each divider starts from dividend[26:11] (already below S).
module softmax_unit #(
    parameter int ARRAYWIDTH          = 4,
    parameter int OUTPUT_BUF_DATASIZE = 32,
    parameter int FIXPOINT_INT        = 22,
    parameter int FIXPOINT_FRAC       = 10
) (
    input  logic          clk,
    input  logic          rst,
    softmax_unit_if.slave bus
);
    localparam int DW  = OUTPUT_BUF_DATASIZE;
    localparam int OW  = FIXPOINT_INT + FIXPOINT_FRAC;
    localparam int QW  = FIXPOINT_FRAC + 1;
    localparam int EW  = 17;
    localparam int SW  = 19;
    localparam int DVW = EW + FIXPOINT_FRAC;

    typedef enum logic [2:0] {S_IDLE, S_MAX, S_EXP, S_SUM, S_DIV, S_DONE} state_t;

    state_t                  r_state;
    logic signed [DW-1:0]    r_x   [ARRAYWIDTH];
    logic signed [DW-1:0]    r_max;
    logic [EW-1:0]           r_e   [ARRAYWIDTH];
    logic [SW-1:0]           r_sum;
    logic [SW-1:0]           r_rem [ARRAYWIDTH];
    logic [QW-1:0]           r_dvd [ARRAYWIDTH];
    logic [QW-1:0]           r_q   [ARRAYWIDTH];
    logic [3:0]              r_cnt;
    logic [ARRAYWIDTH*OW-1:0] r_out;
    logic                    r_out_valid;

    logic signed [DW-1:0]    w_max;
    logic [DW:0]             w_d     [ARRAYWIDTH];
    logic [SW-1:0]           w_sum;
    logic [DVW-1:0]          w_dividend [ARRAYWIDTH];
    logic [SW:0]             w_shift [ARRAYWIDTH];
    logic                    w_ge    [ARRAYWIDTH];
    logic [SW-1:0]           w_diff  [ARRAYWIDTH];

    // e^-k in Q0.16; beyond k=11 the value rounds to zero
    function automatic logic [EW-1:0] exp_lut(input logic [DW:0] d);
        case (d)
            33'd0:   exp_lut = 17'd65536;
            33'd1:   exp_lut = 17'd24109;
            33'd2:   exp_lut = 17'd8869;
            33'd3:   exp_lut = 17'd3263;
            33'd4:   exp_lut = 17'd1200;
            33'd5:   exp_lut = 17'd442;
            33'd6:   exp_lut = 17'd162;
            33'd7:   exp_lut = 17'd60;
            33'd8:   exp_lut = 17'd22;
            33'd9:   exp_lut = 17'd8;
            33'd10:  exp_lut = 17'd3;
            33'd11:  exp_lut = 17'd1;
            default: exp_lut = 17'd0;
        endcase
    endfunction

    always_comb begin
        w_max = r_x[0];
        for (int i = 1; i < ARRAYWIDTH; i++) begin
            if (r_x[i] > w_max) w_max = r_x[i];
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < ARRAYWIDTH; i++) begin
            // 33-bit difference keeps max-positive minus max-negative exact
            w_d[i]        = {r_max[DW-1], r_max} - {r_x[i][DW-1], r_x[i]};
            w_sum         = w_sum + SW'(r_e[i]);
            w_shift[i]    = {r_rem[i], r_dvd[i][QW-1]};
            w_ge[i]       = (w_shift[i] >= {1'b0, r_sum});
            w_diff[i]     = SW'(w_shift[i] - {1'b0, r_sum});
        end
        for (int i = 0; i < ARRAYWIDTH; i++) begin
            w_dividend[i] = {r_e[i], {FIXPOINT_FRAC{1'b0}}} + DVW'(w_sum >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_max       <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < ARRAYWIDTH; i++) begin
                r_x[i]   <= '0;
                r_e[i]   <= '0;
                r_rem[i] <= '0;
                r_dvd[i] <= '0;
                r_q[i]   <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.softmax_en) begin
                        for (int i = 0; i < ARRAYWIDTH; i++) r_x[i] <= bus.Xi[DW*i +: DW];
                        r_state <= S_MAX;
                    end
                end
                S_MAX: begin
                    r_max   <= w_max;
                    r_state <= S_EXP;
                end
                S_EXP: begin
                    for (int i = 0; i < ARRAYWIDTH; i++) r_e[i] <= exp_lut(w_d[i]);
                    r_state <= S_SUM;
                end
                S_SUM: begin
                    r_sum <= w_sum;
                    for (int i = 0; i < ARRAYWIDTH; i++) begin
                        r_rem[i] <= SW'(w_dividend[i][DVW-1:QW]);
                        r_dvd[i] <= w_dividend[i][QW-1:0];
                        r_q[i]   <= '0;
                    end
                    r_cnt   <= '0;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    for (int i = 0; i < ARRAYWIDTH; i++) begin
                        r_rem[i] <= w_ge[i] ? w_diff[i] : w_shift[i][SW-1:0];
                        r_q[i]   <= {r_q[i][QW-2:0], w_ge[i]};
                        r_dvd[i] <= {r_dvd[i][QW-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(QW - 1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    for (int i = 0; i < ARRAYWIDTH; i++) r_out[OW*i +: OW] <= OW'(r_q[i]);
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_softmax_unit.sv
// tb/tb_softmax_unit.sv - directed checks of softmax_unit results, latency, throughput and reset abort
module tb_softmax_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] X1 = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] E1 = 128'h00000021_00000059_000000F3_00000293;

    softmax_unit_if bus();
    softmax_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_row(input string tag, input logic [127:0] x, input logic [127:0] exp);
        int lat;
        @(negedge clk);
        bus.Xi = x;
        bus.softmax_en = 1'b1;
        @(posedge clk);
        #1 bus.softmax_en = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, 128'(lat), 128'd15);
        check({tag, " out"}, bus.out, exp);
        @(posedge clk);
        #1 check({tag, " pulse_end"}, 128'(bus.out_valid), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int v1, v2, pulses;
        bus.softmax_en = 1'b0;
        bus.Xi = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check("reset out", bus.out, 128'd0);
        check("reset out_valid", 128'(bus.out_valid), 128'd0);

        run_row("ascending", X1, E1);
        run_row("equal", 128'h00000005_00000005_00000005_00000005,
                128'h00000100_00000100_00000100_00000100);
        run_row("dominant", 128'd100, 128'h00000000_00000000_00000000_00000400);
        run_row("negative", 128'hFFFFFFFC_FFFFFFFD_FFFFFFFE_FFFFFFFF, E1);
        run_row("reversed", 128'h00000004_00000003_00000002_00000001,
                128'h00000293_000000F3_00000059_00000021);
        run_row("extremes", 128'h80000000_80000000_80000000_7FFFFFFF,
                128'h00000000_00000000_00000000_00000400);

        repeat (5) @(posedge clk);
        #1 check("hold out", bus.out, 128'h00000000_00000000_00000000_00000400);

        // back-to-back rows with enable held high
        @(negedge clk);
        bus.Xi = X1;
        bus.softmax_en = 1'b1;
        @(posedge clk);
        v1 = 0;
        v2 = 0;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                if (v1 == 0) v1 = c;
                else if (v2 == 0) v2 = c;
            end
        end
        bus.softmax_en = 1'b0;
        check("stream first", 128'(v1), 128'd15);
        check("stream second", 128'(v2), 128'd31);
        check("stream out", bus.out, E1);
        repeat (3) @(posedge clk);

        // reset at cycle 7 of a computation
        @(negedge clk);
        bus.Xi = 128'd100;
        bus.softmax_en = 1'b1;
        @(posedge clk);
        #1 bus.softmax_en = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort out", bus.out, 128'd0);
        check("abort out_valid", 128'(bus.out_valid), 128'd0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 if (bus.out_valid) pulses++;
        end
        check("abort no pulse", 128'(pulses), 128'd0);
        check("abort out held", bus.out, 128'd0);

        run_row("after_abort", X1, E1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
